// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared widths, duty type and phase limit for the LED PWM driver
package led_pwm_pkg;
    localparam int NUM_CH = 8;
    localparam int DUTY_W = 8;
    typedef logic [DUTY_W-1:0] duty_t;
    localparam duty_t PHASE_MAX = duty_t'(255);
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one PWM channel with target/active duty and registered compare (LED_PWM_FADE_EN enables ramping)
module led_pwm_channel
    import led_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DUTY_W-1:0] wr_data,
    input  logic              boundary,
    input  logic [DUTY_W-1:0] phase,
`ifdef LED_PWM_FADE_EN
    output logic              differs,
`endif
    output logic              led
);
    duty_t target;
    duty_t active;
    duty_t next_active;
`ifdef LED_PWM_FADE_EN
    // move one count toward the target so brightness changes are gradual
    always_comb next_active = (active < target) ? active + duty_t'(1) : (active > target) ? active - duty_t'(1) : active;
    assign differs = active != target;
`else
    // jump straight to the target
    always_comb next_active = target;
`endif
    // target follows writes; active changes only at boundaries so no period is cut short
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= '0;
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (we) target <= wr_data;
            if (boundary) active <= next_active;
            led <= active > phase;
        end
    end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: eight-channel PWM LED driver with shared prescaler/phase (LED_PWM_FADE_EN enables fade + busy)
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_all,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  leds,
    output logic        period_start,
    output logic        busy
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    logic [PS_W-1:0]   presc;
    duty_t             phase;
    logic              tick;
    logic              boundary;
    logic [NUM_CH-1:0] we;
    assign tick     = presc == PS_LAST;
    assign boundary = tick && phase == PHASE_MAX;
    assign we       = {NUM_CH{wr_all}} | ({NUM_CH{wr_en}} & (NUM_CH'(1) << wr_addr));
    // shared prescaler and phase; period_start marks the first phase-0 cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            phase        <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + PS_W'(1);
            if (tick) phase <= phase + duty_t'(1);
            period_start <= boundary;
        end
    end
`ifdef LED_PWM_FADE_EN
    logic [NUM_CH-1:0] differs;
    // busy while any channel is still ramping toward its target
    always_ff @(posedge clk) begin
        if (rst) busy <= 1'b0;
        else     busy <= |differs;
    end
`else
    assign busy = 1'b0;
`endif
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .we       (we[i]),
            .wr_data  (wr_data),
            .boundary (boundary),
            .phase    (phase),
`ifdef LED_PWM_FADE_EN
            .differs  (differs[i]),
`endif
            .led      (leds[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed, table-driven checks of the PWM driver at PRESCALE=1
module tb_led_pwm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_all = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] leds;
    logic       period_start;
    logic       busy;
    int checks = 0;
    int passed = 0;

    led_pwm_driver #(.PRESCALE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_all       (wr_all),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .leds         (leds),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        all;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ps(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 600);
        if (!period_start) begin
            checks++;
            $display("FAIL %s: period_start not seen within %0d cycles", name, n);
        end
    endtask

    task automatic do_write(input logic en, input logic all, input logic [2:0] addr, input logic [7:0] data);
        wr_en = en;
        wr_all = all;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        wr_all = 1'b0;
    endtask

    task automatic measure(output logic [63:0] cnt);
        cnt = '0;
        repeat (256) begin
            @(negedge clk);
            for (int c = 0; c < 8; c++) cnt[c*8 +: 8] += 8'(leds[c]);
        end
    endtask

    initial begin
        logic [63:0] cnt;
        int ps_hits;
        int first_ps;
        int bad;
        vec_t vecs [5];
        vecs[0] = '{1'b1, 1'b0, 3'd3, 8'd128, 64'h00000000_80000000};
        vecs[1] = '{1'b1, 1'b1, 3'd5, 8'd255, 64'hFFFFFFFF_FFFFFFFF};
        vecs[2] = '{1'b1, 1'b0, 3'd2, 8'd1,   64'hFFFFFFFF_FF01FFFF};
        vecs[3] = '{1'b1, 1'b0, 3'd7, 8'd0,   64'h00FFFFFF_FF01FFFF};
        vecs[4] = '{1'b1, 1'b0, 3'd0, 8'd0,   64'h00FFFFFF_FF01FF00};

        repeat (3) @(negedge clk);
        check("reset leds", 64'(leds), 64'd0);
        check("reset period_start", 64'(period_start), 64'd0);
        check("reset busy", 64'(busy), 64'd0);

        rst = 1'b0;
        ps_hits = 0;
        first_ps = 0;
        bad = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (leds != 8'd0 || busy) bad++;
            if (period_start) begin
                ps_hits++;
                if (first_ps == 0) first_ps = i;
                else if (i - first_ps != 256 * (ps_hits - 1)) bad++;
            end
        end
        check("idle leds/busy/spacing", 64'(bad), 64'd0);
        check("idle first period_start", 64'(first_ps), 64'd256);
        check("idle period_start count", 64'(ps_hits), 64'd2);

`ifndef LED_PWM_FADE_EN
        for (int v = 0; v < 5; v++) begin
            wait_ps("vec sync");
            do_write(vecs[v].en, vecs[v].all, vecs[v].addr, vecs[v].data);
            wait_ps("vec boundary");
            measure(cnt);
            for (int c = 0; c < 8; c++)
                check($sformatf("vec%0d ch%0d duty", v, c), 64'(cnt[c*8 +: 8]), 64'(vecs[v].exp[c*8 +: 8]));
            check($sformatf("vec%0d busy", v), 64'(busy), 64'd0);
        end

        wait_ps("bnd sync");
        repeat (255) @(negedge clk);
        do_write(1'b1, 1'b0, 3'd0, 8'd64);
        check("bnd period_start", 64'(period_start), 64'd1);
        measure(cnt);
        check("bnd write old duty", 64'(cnt[7:0]), 64'd0);
        measure(cnt);
        check("bnd write new duty", 64'(cnt[7:0]), 64'd64);

        do_write(1'b1, 1'b0, 3'd4, 8'd10);
        do_write(1'b1, 1'b0, 3'd4, 8'd20);
        wait_ps("b2b boundary");
        measure(cnt);
        check("b2b last wins", 64'(cnt[39:32]), 64'd20);
`endif

        wait_ps("rst sync");
        do_write(1'b1, 1'b0, 3'd1, 8'd200);
        wait_ps("rst boundary");
        repeat (100) @(negedge clk);
`ifndef LED_PWM_FADE_EN
        check("pre-reset led1 active", 64'(leds[1]), 64'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("mid reset leds", 64'(leds), 64'd0);
        check("mid reset period_start", 64'(period_start), 64'd0);
        check("mid reset busy", 64'(busy), 64'd0);
        rst = 1'b0;
        first_ps = 0;
        for (int i = 1; i <= 300 && first_ps == 0; i++) begin
            @(negedge clk);
            if (period_start) first_ps = i;
        end
        check("post reset first period_start", 64'(first_ps), 64'd256);
        measure(cnt);
        check("post reset targets cleared", cnt, 64'd0);

`ifdef LED_PWM_FADE_EN
        wait_ps("fade sync");
        do_write(1'b1, 1'b0, 3'd7, 8'd4);
        @(negedge clk);
        check("fade busy rises", 64'(busy), 64'd1);
        wait_ps("fade first boundary");
        for (int s = 1; s <= 4; s++) begin
            measure(cnt);
            check($sformatf("fade step %0d duty", s), 64'(cnt[63:56]), 64'(s));
            check($sformatf("fade step %0d busy", s), 64'(busy), 64'(s < 4));
        end
        measure(cnt);
        check("fade settled duty", 64'(cnt[63:56]), 64'd4);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Eight-channel PWM brightness driver that produces the `leds[7:0]` vector consumed by the PMOD LED output stage. Host logic writes an 8-bit brightness target per channel. Each channel's active duty is updated only at PWM period boundaries, so outputs never glitch mid-period. An optional fade mode ramps active duty toward the target one step per period.

## Interface
- `PRESCALE`, default 4: system clocks per PWM phase step; legal range ≥1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe, one channel per cycle; always accepted, no backpressure.
- `wr_all`  in  1  write `wr_data` to all eight targets; overrides `wr_addr` when both `wr_all` and `wr_en` are high.
- `wr_addr`  in  3  channel index for `wr_en`.
- `wr_data`  in  8  brightness target: 0 = off, 255 = on for 255/256 of the period.
- `leds`  out  8  registered PWM outputs; bit i is channel i.
- `period_start`  out  1  one-cycle pulse in the cycle phase becomes 0.
- `busy`  out  1  high while any active duty ≠ its target (fade builds only; tied 0 otherwise).

## Operation
- Reset values: prescaler 0; phase 0; targets 0; active duties 0; `leds` 0; `period_start` 0; `busy` 0.
- Prescaler counts 0..PRESCALE-1. Tick = prescaler at PRESCALE-1; the prescaler then wraps to 0.
- Phase is an 8-bit counter that advances on each tick and wraps 255→0. Boundary = tick while phase = 255.
- On a boundary, each active duty updates. The new value is used from phase 0 onward.
  - Without fade: active ← target.
  - With fade: active moves ±1 toward target; no change if equal.
- Every cycle, `leds[i]` ← (active[i] > phase). Unsigned 8-bit compare.
- Writes update the target register at the clock edge. A write in the boundary cycle itself is not seen by that boundary: active takes the pre-write target, and the new target applies at the next boundary.
- Back-to-back writes to the same channel: last one wins.
- Reset asserted mid-period forces all state to reset values on the next edge. The period restarts from phase 0.

## Timing
- PWM period = 256·PRESCALE clocks.
- `leds` lags the phase/active values by 1 clock (registered compare).
- `period_start` is combinationally asserted in the boundary cycle, registered so it appears one clock before the first `leds` update of the new period.
- Write-to-output latency without fade: 1 to 256·PRESCALE clocks until the next boundary, then +1.
- Fade from a to b takes |a−b| periods.

## Configuration
- `LED_PWM_FADE_EN` defined:
  - fade stepping as above.
  - `busy` = OR over channels of (active ≠ target), registered.
- `LED_PWM_FADE_EN` undefined:
  - active ← target at every boundary.
  - `busy` tied 0.
  - no fade comparators synthesized.

## Structure
- Package `led_pwm_pkg` holds:
  - `NUM_CH` = 8 and `DUTY_W` = 8.
  - typedef `duty_t` (8-bit unsigned).
  - `PHASE_MAX` = 255.
- Top level holds the shared prescaler, phase counter, and write decode.
- Sub-module `led_pwm_channel`, instantiated ×8. It holds:
  - target and active registers.
  - boundary update, with the fade step under the macro.
  - registered compare output.

## Test plan
- Reset, PRESCALE=1, no writes for 600 clocks → `leds`=0x00 throughout, `period_start` every 256 clocks, `busy`=0.
- Write ch3=128, no fade → after the next boundary, `leds[3]` high exactly 128 of every 256 clocks; other bits 0.
- `wr_all`=1 with `wr_en`=1, `wr_addr`=5, data 255 → all eight channels high for 255 clocks and low for 1 per period.
- Write ch0=64 in the boundary cycle → the following period still uses the old duty 0; duty 64 starts one period later.
- Fade build: ch7 0→4 → active steps 1,2,3,4 over four periods; `busy` high until active=4, then low.
- Assert `rst` at phase 100 with ch1=200 → next clock: `leds`=0, phase=0, targets cleared; no PWM activity until rewritten.
